// File: rtl/idli_trace_m.sv
// Execution-trace capture for the idli core: reassembles nibble-serial channels,
// timestamps each instruction-done strobe and queues the records in a FIFO.
module idli_trace_m #(
    parameter int WIDTH    = 16,
    parameter int LANE     = 4,
    parameter int CHANNELS = 2,
    parameter int DEPTH    = 8,
    parameter int OFFSET   = 1,
    parameter int TS_W     = 16
) (
    input  logic                         i_trc_gck,
    input  logic                         i_trc_rst,
    input  logic                         i_trc_en,
    input  logic                         i_trc_done,
    input  logic [CHANNELS*LANE-1:0]     i_trc_lane,
    input  logic                         i_trc_clr,
    output logic                         o_trc_vld,
    input  logic                         i_trc_rdy,
    output logic [CHANNELS*WIDTH-1:0]    o_trc_data,
    output logic [TS_W-1:0]              o_trc_ts,
    output logic [$clog2(DEPTH+1)-1:0]   o_trc_level,
    output logic                         o_trc_ovf
);

    localparam int LVL_W = $clog2(DEPTH+1);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int REC_W = CHANNELS*WIDTH + TS_W;
    localparam logic [WIDTH-1:0] OFF_W = WIDTH'(OFFSET);
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

    logic [WIDTH-1:0] r_word [CHANNELS];
    logic [WIDTH-1:0] w_word_d [CHANNELS];
    logic [REC_W-1:0] r_mem [DEPTH];
    logic [REC_W-1:0] w_rec;
    logic [REC_W-1:0] w_head;
    logic [TS_W-1:0]  r_ts;
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [LVL_W-1:0] r_level;
    logic             r_ovf;
    logic             w_push;
    logic             w_pop;
    logic             w_full;
    logic             w_wr;

    // Each channel shifts right, newest beat entering at the MSB end.
    always_comb begin
        for (int c = 0; c < CHANNELS; c++) begin
            w_word_d[c] = {i_trc_lane[c*LANE +: LANE], r_word[c][WIDTH-1:LANE]};
        end
    end

    // Record layout: {channel words (ch0 offset-corrected), timestamp}.
    always_comb begin
        w_rec = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            w_rec[TS_W + c*WIDTH +: WIDTH] = w_word_d[c];
        end
        w_rec[TS_W +: WIDTH] = w_word_d[0] - OFF_W;
        w_rec[TS_W-1:0]      = r_ts;
    end

    // Valid/ready: a record transfers on any cycle where o_trc_vld && i_trc_rdy;
    // the head is held stable while o_trc_vld && !i_trc_rdy. Clear overrides both.
    assign w_full = (r_level == FULL_LVL);
    assign w_push = i_trc_done && i_trc_en && !i_trc_clr;
    assign w_pop  = o_trc_vld && i_trc_rdy && !i_trc_clr;
    assign w_wr   = w_push && (!w_full || w_pop);

    always_ff @(posedge i_trc_gck) begin
        if (w_wr) begin
            r_mem[r_wptr] <= w_rec;
        end
    end

    always_ff @(posedge i_trc_gck or posedge i_trc_rst) begin
        if (i_trc_rst) begin
            for (int c = 0; c < CHANNELS; c++) begin
                r_word[c] <= '0;
            end
            r_ts    <= '0;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
            r_ovf   <= 1'b0;
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                r_word[c] <= w_word_d[c];
            end
            r_ts <= r_ts + TS_W'(1);
            if (i_trc_clr) begin
                r_wptr  <= '0;
                r_rptr  <= '0;
                r_level <= '0;
                r_ovf   <= 1'b0;
            end else begin
                if (w_wr) begin
                    r_wptr <= r_wptr + PTR_W'(1);
                end
                if (w_pop) begin
                    r_rptr <= r_rptr + PTR_W'(1);
                end
                if (w_push && w_full && !w_pop) begin
                    r_ovf <= 1'b1;
                end
                if (w_wr && !w_pop) begin
                    r_level <= r_level + LVL_W'(1);
                end else if (!w_wr && w_pop) begin
                    r_level <= r_level - LVL_W'(1);
                end
            end
        end
    end

    // Head is gated so an empty or freshly reset FIFO reads as zero.
    assign w_head      = r_mem[r_rptr];
    assign o_trc_vld   = (r_level != '0);
    assign o_trc_data  = o_trc_vld ? w_head[REC_W-1:TS_W] : '0;
    assign o_trc_ts    = o_trc_vld ? w_head[TS_W-1:0] : '0;
    assign o_trc_level = r_level;
    assign o_trc_ovf   = r_ovf;

endmodule
